// File: rtl/vdp_irq_pkg.sv
// Shared helpers for the VDP interrupt-request latch.
// Holds the next-state rule so that other status logic can reuse it.
package vdp_irq_pkg;

  // A new event beats a simultaneous acknowledge, so no request is ever dropped.
  function automatic logic irq_next(input logic irq_cur,
                                    input logic set_tick,
                                    input logic ack_tick);
    return set_tick | (irq_cur & ~ack_tick);
  endfunction

endpackage

// File: rtl/vdp_irq.sv
// VDP interrupt-request latch: set by the frame tick, cleared by a status-register read.
// The output comes straight from the flop, so there is no path from the strobes to irq.
module vdp_irq
  import vdp_irq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq_tick,
  input  logic rd_tick,
  output logic irq
);

  logic irq_d;
  logic irq_q;

  always_comb begin
    irq_d = irq_next(irq_q, irq_tick, rd_tick);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_vdp_irq.sv
// Directed bench for vdp_irq: expected irq values are queued when a step is driven
// and checked once the DUT has had its clock edge.
module tb_vdp_irq;

  logic clk;
  logic reset;
  logic irq_tick;
  logic rd_tick;
  logic irq;

  int errors;
  int checks;

  typedef struct {
    string tag;
    logic  exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  vdp_irq u_dut (
    .clk     (clk),
    .reset   (reset),
    .irq_tick(irq_tick),
    .rd_tick (rd_tick),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic pop_check();
    sb_item_t it;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed irq=%b required a queued expectation", irq);
    end else begin
      it = sb_q.pop_front();
      checks++;
      assert (irq === it.exp)
      else begin
        errors++;
        $error("FAIL %s: observed irq=%b required %b", it.tag, irq, it.exp);
      end
    end
  endtask

  // Check the current output without advancing time.
  task automatic check_now(input string tag, input logic exp);
    push_exp(tag, exp);
    pop_check();
  endtask

  // Drive strobes (caller sits at a negedge), clock once, check just after the edge.
  task automatic cyc(input string tag, input logic t, input logic r, input logic exp);
    irq_tick = t;
    rd_tick  = r;
    push_exp(tag, exp);
    @(posedge clk);
    #1;
    pop_check();
    @(negedge clk);
    irq_tick = 1'b0;
    rd_tick  = 1'b0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b0;
    irq_tick = 1'b0;
    rd_tick  = 1'b0;

    // Reset held for three clocks, with a request strobe that must be ignored.
    @(negedge clk);
    irq_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_now("reset_hold", 1'b0);
    end
    irq_tick = 1'b0;
    reset    = 1'b1;
    check_now("reset_release", 1'b0);

    cyc("read_no_req", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("read_cont_no_req", 1'b0, 1'b1, 1'b0);

    // Set and hold.
    cyc("set", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("hold", 1'b0, 1'b0, 1'b1);
    cyc("set_again", 1'b1, 1'b0, 1'b1);
    cyc("read_clear", 1'b0, 1'b1, 1'b0);
    cyc("read_idle", 1'b0, 1'b1, 1'b0);

    // Simultaneous set and read while clear: set wins.
    check_now("simul_pre", 1'b0);
    cyc("simul_post", 1'b1, 1'b1, 1'b1);
    check_now("simul_negedge", 1'b1);
    check_now("simul_read_pre", 1'b1);
    cyc("simul_read_post", 1'b0, 1'b1, 1'b0);

    // Back-to-back set then read.
    check_now("b2b_pre", 1'b0);
    cyc("b2b_set", 1'b1, 1'b0, 1'b1);
    cyc("b2b_read", 1'b0, 1'b1, 1'b0);

    // Saturation: both strobes for three cycles, then a lone read.
    for (int i = 0; i < 3; i++) cyc("sat_overlap", 1'b1, 1'b1, 1'b1);
    cyc("sat_final_read", 1'b0, 1'b1, 1'b0);
    cyc("sat_after", 1'b0, 1'b0, 1'b0);

    // Alternating set/read, then idle and a stray read.
    cyc("alt_set0", 1'b1, 1'b0, 1'b1);
    cyc("alt_rd0", 1'b0, 1'b1, 1'b0);
    cyc("alt_set1", 1'b1, 1'b0, 1'b1);
    cyc("alt_rd1", 1'b0, 1'b1, 1'b0);
    cyc("alt_idle", 1'b0, 1'b0, 1'b0);
    cyc("alt_rd2", 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while a request is pending, between clock edges.
    cyc("async_set", 1'b1, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_now("async_reset_immediate", 1'b0);
    irq_tick = 1'b1;
    @(posedge clk);
    #1;
    check_now("async_reset_held", 1'b0);
    @(negedge clk);
    irq_tick = 1'b0;
    reset    = 1'b1;
    cyc("after_reset_idle", 1'b0, 1'b0, 1'b0);
    cyc("after_reset_set", 1'b1, 1'b0, 1'b1);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vdp_irq.md
Name: vdp_irq

Overview:
- Interrupt-request latch for the VDP (TMS99xx-style video display processor).
- Set by a one-clock frame/vblank tick from the video timing generator.
- Held until the CPU reads the VDP status register, which produces a one-clock read tick.
- Drives the VDP interrupt output toward the CPU interrupt logic.

Parameters:
- none

Ports:
- clk  input  1  pixel clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset. Low forces irq to 0 immediately, regardless of clk.
- irq_tick  input  1  interrupt-event strobe, synchronous to clk. Each clk edge sampling it high is one event; a level held for several cycles counts as repeated events.
- rd_tick  input  1  status-read strobe, synchronous to clk. Each clk edge sampling it high is one read/acknowledge.
- irq  output  1  registered interrupt request, active-high, level-held.

Behaviour:
- One flip-flop; irq is driven directly by it (registered, no combinational path from the inputs).
- Reset: while reset is low, irq = 0, asynchronously. After reset deasserts, the first evaluation is at the next rising clk.
- Each rising clk edge, with reset high:
  - next irq = irq_tick OR (irq AND NOT rd_tick).
- irq_tick = 1: irq = 1 from the edge that samples it (1-clock latency from strobe to output).
- rd_tick = 1, irq_tick = 0: irq = 0 after that edge.
  - Reading while irq is already 0 has no effect.
  - Continuous rd_tick keeps irq at 0.
- Neither strobe: irq holds. There is no timeout and no auto-clear.
- Repeated irq_tick while irq = 1: irq stays 1. No counting and no queuing; one read clears all pending events.
- Simultaneous irq_tick and rd_tick at the same edge: set wins, so irq = 1 after the edge.
  - If irq was 0, the CPU read in that cycle returns irq = 0 (pre-edge value). The new request is visible from the next cycle and must be consumed by a later read.
  - If irq was 1, it stays 1. The new event is not lost, so a further read is required.
- irq_tick at edge N, then rd_tick at edge N+1: irq = 1 after N and 0 after N+1. The CPU read in cycle N+1 returns irq = 1 (consume the just-raised request).
- Both strobes held high on every cycle: irq stays 1 continuously.
- Reset mid-operation: irq goes to 0 immediately; any pending request is discarded.
- The status-register data path (returning the irq value to the CPU) is outside this block. The read returns the pre-edge irq value.

Decomposition:
- No package types or constants needed.
- No sub-modules; a single always block with asynchronous reset implements the flop.
- Instantiated inside the VDP top level alongside the timing generator and status-register logic.

Test Plan:
- Reset: drive reset low for 3 clocks, then high -> irq = 0 throughout and after. Single rd_tick and a 3-cycle continuous rd_tick with no request -> irq remains 0.
- Set and hold: 1-cycle irq_tick -> irq = 1 at the next clk edge and stays 1 for ≥3 idle cycles. Second irq_tick while set -> irq stays 1. One rd_tick -> irq = 0 after that edge. Another rd_tick -> irq stays 0.
- Simultaneous with irq = 0: rd_tick = irq_tick = 1 for one cycle -> irq = 0 just before the edge and irq = 1 by the following negedge. Subsequent 1-cycle rd_tick -> irq still 1 at that posedge, 0 by the following negedge.
- Back-to-back: irq_tick at edge N, rd_tick at edge N+1 -> irq = 0 before N, 1 after N, 0 after N+1.
- Saturation: rd_tick = irq_tick = 1 for 3 cycles, then irq_tick = 0 with rd_tick still 1 for one more cycle -> irq = 1 during the overlap, 0 one edge after the final read.
- Alternating: sequence irq_tick, rd_tick, irq_tick, rd_tick, idle, rd_tick (one per cycle) -> irq toggles 1,0,1,0, then stays 0. Also assert async reset low mid-sequence with irq = 1 -> irq = 0 without waiting for clk.
